// File: rtl/vram_pkg.sv
// Shared FSM state type and default geometry (800x600, 12-bit pixels) for the VRAM arbiter.
package vram_pkg;
  localparam int VRAM_AW   = 19;
  localparam int VRAM_DW   = 12;
  localparam int VRAM_NPIX = 480000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } vram_state_t;
endpackage

// File: rtl/vram_delay2.sv
// Two-stage register pipe that lines timing signals up with the registered pixel data.
module vram_delay2 #(
  parameter int W = 3
) (
  input  logic         pclk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scan-out owns the port during active video, the CPU is served in blanking.
// Build option VRAM_ARB_STAT_EN adds cpu_wait_max, the longest CPU stall since reset.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int AW   = VRAM_AW,
  parameter int DW   = VRAM_DW,
  parameter int NPIX = VRAM_NPIX
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          hen,
  input  logic          ven,
  input  logic          hs,
  input  logic          vs,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  output logic          hs_o,
  output logic          vs_o,
  output vram_state_t   fsm_state
`ifdef VRAM_ARB_STAT_EN
  ,
  output logic [15:0]   cpu_wait_max
`endif
);
  logic          disp_active;
  logic          grant;
  logic [AW-1:0] pix_addr;
  vram_state_t   state;

  // CPU handshake: cpu_req (with we/addr/wdata) is held until cpu_ack; the access
  // happens on the edge ending the grant cycle and cpu_ack pulses for exactly the
  // following cycle, carrying read data. Reset during that cycle drops the access.
  assign disp_active = hen & ven;
  assign grant       = rst && (state == ST_IDLE) && cpu_req && !disp_active;
  assign fsm_state   = state;
  assign cpu_rdata   = cpu_ack ? ram_rdata : '0;

  always_comb begin
    ram_addr  = pix_addr;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (grant) begin
      ram_addr  = cpu_addr;
      ram_we    = cpu_we;
      ram_wdata = cpu_wdata;
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cpu_ack <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cpu_ack <= grant;
          if (grant) state <= ST_ACK;
        end
        ST_ACK: begin
          cpu_ack <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          cpu_ack <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  // vs has priority so a frame always restarts from pixel 0, even mid-line.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      pix_addr <= '0;
      pix_data <= '0;
    end else begin
      pix_data <= ram_rdata;
      if (vs) pix_addr <= '0;
      else if (disp_active) pix_addr <= (pix_addr == AW'(NPIX - 1)) ? '0 : pix_addr + 1'b1;
    end
  end

  vram_delay2 #(.W(3)) u_delay (
    .pclk (pclk),
    .rst  (rst),
    .d    ({disp_active, hs, vs}),
    .q    ({pix_valid, hs_o, vs_o})
  );

`ifdef VRAM_ARB_STAT_EN
  logic [15:0] wait_cnt;
  logic [15:0] wait_nxt;

  // The ACK cycle is the tail of a completed access, not a stall.
  always_comb begin
    wait_nxt = '0;
    if (cpu_req && !grant && state == ST_IDLE)
      wait_nxt = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      wait_cnt     <= '0;
      cpu_wait_max <= '0;
    end else begin
      wait_cnt <= wait_nxt;
      if (wait_nxt > cpu_wait_max) cpu_wait_max <= wait_nxt;
    end
  end
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised scoreboard bench for vram_arbiter with a behavioural VRAM and arbitration model.
// Define VRAM_ARB_STAT_EN to also exercise cpu_wait_max.
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int AW   = 12;
  localparam int DW   = 12;
  localparam int NPIX = 1000;
  localparam int AKW  = 32 + 1 + DW;  // {cycle, is_read, data}
  localparam int PXW  = 32 + DW;      // {cycle, data}
  localparam int HVW  = 32 + 3;       // {cycle, valid, hs, vs}
  localparam int OPW  = 1 + AW + DW;  // {we, addr, wdata}

  logic          pclk = 1'b0;
  logic          rst = 1'b0;
  logic          hen = 1'b0, ven = 1'b0, hs = 1'b0, vs = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [DW-1:0] pix_data;
  logic          pix_valid, hs_o, vs_o;
  vram_state_t   fsm_state;
`ifdef VRAM_ARB_STAT_EN
  logic [15:0]   cpu_wait_max;
`endif

  vram_arbiter #(.AW(AW), .DW(DW), .NPIX(NPIX)) dut (
    .pclk(pclk), .rst(rst), .hen(hen), .ven(ven), .hs(hs), .vs(vs),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .pix_data(pix_data), .pix_valid(pix_valid), .hs_o(hs_o), .vs_o(vs_o),
    .fsm_state(fsm_state)
`ifdef VRAM_ARB_STAT_EN
    , .cpu_wait_max(cpu_wait_max)
`endif
  );

  // ---------------- clock ----------------
  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // ---------------- VRAM model and expected contents ----------------
  logic [DW-1:0] mem    [2**AW];
  logic [DW-1:0] shadow [2**AW];
  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      mem[i]    = DW'(i * 37 + 5);
      shadow[i] = DW'(i * 37 + 5);
    end
  end

  always @(posedge pclk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // ---------------- scoreboard state ----------------
  logic [AKW-1:0] exp_q[$];
  logic [PXW-1:0] pix_q[$];
  logic [HVW-1:0] hv_q[$];
  logic [OPW-1:0] op_q[$];
  int   cmp_cnt = 0;
  int   err_cnt = 0;
  int   ack_seen = 0;
  int   grants = 0;
  logic m_ack = 1'b0;
  logic m_grant = 1'b0;
  int   pa = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // One pclk cycle of stimulus plus the reference model's view of that cycle.
  task automatic step(input logic h, input logic v, input logic hsi, input logic vsi);
    logic          disp;
    logic [AW-1:0] e_addr;
    logic          e_we;
    logic [DW-1:0] e_wd;
    @(posedge pclk);
    #1;
    if (m_ack && op_q.size() > 0) void'(op_q.pop_front());
    m_ack = m_grant;
    hen = h; ven = v; hs = hsi; vs = vsi;
    disp = h & v;
    if (op_q.size() > 0) begin
      cpu_req = 1'b1;
      {cpu_we, cpu_addr, cpu_wdata} = op_q[0];
    end else begin
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    end
    m_grant = rst && cpu_req && !disp && !m_ack;
    e_addr = AW'(pa); e_we = 1'b0; e_wd = '0;
    if (m_grant) begin
      grants++;
      e_addr = cpu_addr; e_we = cpu_we; e_wd = cpu_wdata;
      if (cpu_we) begin
        shadow[cpu_addr] = cpu_wdata;
        exp_q.push_back({32'(cyc + 1), 1'b0, DW'(0)});
      end else begin
        exp_q.push_back({32'(cyc + 1), 1'b1, shadow[cpu_addr]});
      end
    end
    if (disp && rst) pix_q.push_back({32'(cyc + 2), shadow[pa]});
    hv_q.push_back({32'(cyc + 2), disp & rst, hsi & rst, vsi & rst});
    if (!rst || vsi) pa = 0;
    else if (disp) pa = (pa + 1) % NPIX;
    #1;
    chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    chk("ram_we", 32'(ram_we), 32'(e_we));
    chk("ram_wdata", 32'(ram_wdata), 32'(e_wd));
  endtask

  task automatic maybe_op();
    logic [AW-1:0] a;
    if ($urandom_range(0, 5) == 0 && op_q.size() < 4) begin
      a = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 31)) : AW'($urandom);
      op_q.push_back({1'($urandom_range(0, 1)), a, DW'($urandom)});
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge pclk) begin
    logic [AKW-1:0] a;
    logic [PXW-1:0] p;
    logic [HVW-1:0] x;
    logic           exp_ack;
    if (cpu_ack) ack_seen++;
    while (exp_q.size() > 0 && int'(exp_q[0][AKW-1 -: 32]) < cyc) void'(exp_q.pop_front());
    exp_ack = 1'b0;
    if (exp_q.size() > 0) begin
      a = exp_q[0];
      exp_ack = (int'(a[AKW-1 -: 32]) == cyc);
    end
    chk("cpu_ack", 32'(cpu_ack), 32'(exp_ack));
    if (exp_ack) begin
      a = exp_q.pop_front();
      if (a[DW] && cpu_ack) chk("cpu_rdata", 32'(cpu_rdata), 32'(a[DW-1:0]));
    end
    while (hv_q.size() > 0 && int'(hv_q[0][HVW-1 -: 32]) < cyc) void'(hv_q.pop_front());
    if (hv_q.size() > 0 && int'(hv_q[0][HVW-1 -: 32]) == cyc) begin
      x = hv_q.pop_front();
      chk("pix_valid", 32'(pix_valid), 32'(x[2]));
      chk("hs_o", 32'(hs_o), 32'(x[1]));
      chk("vs_o", 32'(vs_o), 32'(x[0]));
    end
    while (pix_q.size() > 0 && int'(pix_q[0][PXW-1 -: 32]) < cyc) void'(pix_q.pop_front());
    if (pix_q.size() > 0 && int'(pix_q[0][PXW-1 -: 32]) == cyc) begin
      p = pix_q.pop_front();
      chk("pix_data", 32'(pix_data), 32'(p[DW-1:0]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    rst = 1'b0;
    repeat (3) @(posedge pclk);
    #2;
    chk("rst_cpu_ack", 32'(cpu_ack), 32'(0));
    chk("rst_pix_valid", 32'(pix_valid), 32'(0));
    chk("rst_pix_data", 32'(pix_data), 32'(0));
    chk("rst_hs_o", 32'(hs_o), 32'(0));
    chk("rst_vs_o", 32'(vs_o), 32'(0));
    chk("rst_ram_addr", 32'(ram_addr), 32'(0));
    chk("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    rst = 1'b1;

    // First pixels of a frame: addresses 0..3, data two cycles later.
    step(0, 0, 0, 1);
    repeat (4) step(1, 1, 0, 0);
    repeat (3) step(0, 0, 1, 0);

    // Write 0xABC to 0x010, then read it back.
    op_q.push_back({1'b1, AW'(16), DW'(12'hABC)});
    repeat (3) step(0, 0, 0, 0);
    op_q.push_back({1'b0, AW'(16), DW'(0)});
    repeat (3) step(0, 0, 0, 0);

    // Three requests held over six blanking cycles: three acks.
    base = ack_seen;
    for (int i = 0; i < 3; i++) op_q.push_back({1'b0, AW'(40 + i), DW'(0)});
    repeat (6) step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("b2b_ack_count", 32'(ack_seen - base), 32'(3));

    // Request rising with active video waits out the whole line.
    op_q.push_back({1'b0, AW'(16), DW'(0)});
    repeat (800) step(1, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0);

    // Frame wrap at NPIX-1 and a mid-line vs.
    step(0, 0, 0, 1);
    repeat (NPIX + 2) step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    repeat (3) step(1, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0);

    // Reset during the ACK cycle drops the access.
    op_q.push_back({1'b0, AW'(7), DW'(0)});
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ack", 32'(cpu_ack), 32'(0));
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    grants--;
    m_grant = 1'b0; m_ack = 1'b0; pa = 0;
    op_q.delete();
    repeat (3) step(0, 0, 0, 0);
    rst = 1'b1;
    op_q.push_back({1'b0, AW'(7), DW'(0)});
    repeat (4) step(0, 0, 0, 0);

`ifdef VRAM_ARB_STAT_EN
    op_q.push_back({1'b0, AW'(9), DW'(0)});
    repeat (10) step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("cpu_wait_max", 32'(cpu_wait_max), 32'(10));
    repeat (2) step(0, 0, 0, 0);
`endif

    // Randomised lines with video dropouts and CPU traffic.
    for (int line = 0; line < 25; line++) begin
      int len;
      if (line % 8 == 0) begin maybe_op(); step(0, 0, 0, 1); end
      len = $urandom_range(40, 120);
      for (int i = 0; i < len; i++) begin
        maybe_op();
        step(1, 1'($urandom_range(0, 15) != 0), 0, 0);
      end
      len = $urandom_range(8, 25);
      for (int i = 0; i < len; i++) begin
        maybe_op();
        step(0, 0, 1'(i < 3), 0);
      end
    end
    repeat (12) step(0, 0, 0, 0);
    chk("total_acks", 32'(ack_seen), 32'(grants));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 19, meaning the VRAM word address width.
REQ-002 The block SHALL have parameter DW, default 12, meaning the pixel/VRAM word width.
REQ-003 The block SHALL have parameter NPIX, default 480000, meaning active pixels per frame (800x600).
REQ-004 Port pclk  in  1  pixel clock; the only clock.
REQ-005 Port rst  in  1  reset; asynchronous, active-low.
REQ-006 Port hen, ven, hs, vs  in  1 each  timing-generator enables/syncs, synchronous to pclk.
REQ-007 Port cpu_req  in  1  CPU access request; held high until cpu_ack.
REQ-008 Port cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
REQ-009 Port cpu_addr  in  AW  CPU word address; stable while cpu_req is high.
REQ-010 Port cpu_wdata  in  DW  CPU write data; stable while cpu_req is high.
REQ-011 Port cpu_ack  out  1  one-cycle access-complete pulse.
REQ-012 Port cpu_rdata  out  DW  read data, valid only while cpu_ack=1.
REQ-013 Port ram_addr / ram_we / ram_wdata  out  AW/1/DW  single-port synchronous VRAM command.
REQ-014 Port ram_rdata  in  DW  VRAM read data, valid one cycle after the address edge.
REQ-015 Port pix_data  out  DW  registered pixel for scan-out.
REQ-016 Port pix_valid, hs_o, vs_o  out  1 each  disp_active, hs and vs each delayed 2 cycles to align with pix_data.

Function
REQ-017 disp_active SHALL equal hen&ven; while disp_active=1 the display SHALL own the RAM port: ram_addr=pix_addr, ram_we=0.
REQ-018 pix_addr SHALL increment by 1 each cycle disp_active=1, wrap NPIX-1 -> 0, and clear to 0 on any cycle vs=1.
REQ-019 pix_data SHALL register ram_rdata every cycle; total display latency from disp_active to pix_valid/pix_data SHALL be 2 cycles.
REQ-020 FSM states: IDLE, ACK; reset state IDLE.
REQ-021 Grant: in IDLE with cpu_req=1 and disp_active=0, ram_addr=cpu_addr, ram_we=cpu_we, ram_wdata=cpu_wdata (combinational), next state ACK.
REQ-022 ACK: cpu_ack=1, cpu_rdata=ram_rdata (zero-latency pass-through), no new grant; next state IDLE unconditionally.
REQ-023 Maximum CPU throughput SHALL be one access per 2 cycles; back-to-back requests held high are granted again in the cycle after ACK.
REQ-024 Simultaneous cpu_req and disp_active=1: display wins; the CPU waits with no ack until a blanking cycle.
REQ-025 disp_active rising while in ACK: ACK still completes (the RAM access occurred on the prior edge); the display owns the port that cycle.
REQ-026 When not granted and not displaying: ram_we=0, ram_addr=pix_addr, ram_wdata=0.

Reset
REQ-027 While rst=0: state IDLE, pix_addr=0, cpu_ack=0, pix_data=0, pix_valid=0, hs_o=0, vs_o=0, delay pipes cleared.
REQ-028 Reset asserted during ACK SHALL drop the access; no ack is issued after release, and the requester must re-request.

Configuration
REQ-029 With VRAM_ARB_STAT_EN defined: output cpu_wait_max (16 bits) SHALL hold the largest count of consecutive cycles cpu_req=1 without grant (saturating at 65535), cleared by reset; without it the port and its logic SHALL be absent.

Structure
REQ-030 A shared package vram_pkg SHALL hold the FSM state typedef and the default AW/DW/NPIX constants.
REQ-031 One sub-module, vram_delay2, SHALL implement the 2-stage alignment pipe for pix_valid/hs/vs.

Verification
REQ-032 hen=ven=1 for 4 cycles after vs: ram_addr 0,1,2,3; pix_valid high 2 cycles later carrying rdata of addr 0..3.
REQ-033 Blanking, cpu_req write addr 0x00010 data 0xABC: ram_we=1 same cycle, cpu_ack next cycle; a later read of 0x00010 returns 0xABC with ack.
REQ-034 cpu_req held 6 blanking cycles: exactly 3 acks, on cycles 2, 4, 6.
REQ-035 cpu_req raised in the same cycle as hen&ven rising, active for 800 cycles: no ack until the first blanking cycle, ack 1 cycle later.
REQ-036 pix_addr at 479999 with disp_active: next address 0; vs pulse mid-line clears pix_addr to 0.
REQ-037 rst=0 asserted during ACK: cpu_ack=0 immediately and stays 0 after release; with VRAM_ARB_STAT_EN, 10 blocked cycles give cpu_wait_max=10.
